// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the registered ALU.
//   ALU_WIDTH   default operand/result width
//   OP_*        4-bit operation select encodings
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_SHL  = 4'd4;
   localparam logic [3:0] OP_SHR  = 4'd5;
   localparam logic [3:0] OP_ROL  = 4'd6;
   localparam logic [3:0] OP_ROR  = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_XOR  = 4'd10;
   localparam logic [3:0] OP_NOR  = 4'd11;
   localparam logic [3:0] OP_NAND = 4'd12;
   localparam logic [3:0] OP_XNOR = 4'd13;
   localparam logic [3:0] OP_GT   = 4'd14;
   localparam logic [3:0] OP_EQ   = 4'd15;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational datapath of the ALU.
//   a, b        unsigned operands
//   sel         operation select (alu_pkg OP_*)
//   result_nxt  operation result, modulo 2^WIDTH
//   carry_nxt   carry / borrow / overflow / divide-error flag
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
   output logic [WIDTH-1:0] result_nxt,
   output logic             carry_nxt
);

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;

   // One extra bit on add/sub exposes carry and borrow directly.
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};
   assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   always_comb begin
      result_nxt = '0;
      carry_nxt  = 1'b0;
      case (sel)
         OP_ADD: begin
            result_nxt = sum[WIDTH-1:0];
            carry_nxt  = sum[WIDTH];
         end
         OP_SUB: begin
            result_nxt = diff[WIDTH-1:0];
            carry_nxt  = diff[WIDTH];
         end
         OP_MUL: begin
            result_nxt = prod[WIDTH-1:0];
            carry_nxt  = |prod[2*WIDTH-1:WIDTH];
         end
         OP_DIV: begin
            // Divide by zero is flagged and forced to all ones so no X escapes.
            if (b == '0) begin
               result_nxt = '1;
               carry_nxt  = 1'b1;
            end else begin
               result_nxt = a / b;
            end
         end
         OP_SHL: begin
            result_nxt = {a[WIDTH-2:0], 1'b0};
            carry_nxt  = a[WIDTH-1];
         end
         OP_SHR: begin
            result_nxt = {1'b0, a[WIDTH-1:1]};
            carry_nxt  = a[0];
         end
         OP_ROL: begin
            result_nxt = {a[WIDTH-2:0], a[WIDTH-1]};
            carry_nxt  = a[WIDTH-1];
         end
         OP_ROR: begin
            result_nxt = {a[0], a[WIDTH-1:1]};
            carry_nxt  = a[0];
         end
         OP_AND:  result_nxt = a & b;
         OP_OR:   result_nxt = a | b;
         OP_XOR:  result_nxt = a ^ b;
         OP_NOR:  result_nxt = ~(a | b);
         OP_NAND: result_nxt = ~(a & b);
         OP_XNOR: result_nxt = ~(a ^ b);
         OP_GT:   result_nxt[0] = (a > b);
         OP_EQ:   result_nxt[0] = (a == b);
         default: begin
            result_nxt = '0;
            carry_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu.sv
// alu: registered ALU, one-cycle latency, new operation every cycle.
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   a, b       unsigned operands
//   alu_sel    operation select (alu_pkg OP_*)
//   result     registered result
//   carry_out  registered carry / borrow / error flag
//   zero       registered, 1 when result is all zeros
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_sel,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero
);

   logic [WIDTH-1:0] result_nxt;
   logic             carry_nxt;

   alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
      .a          (a),
      .b          (b),
      .sel        (alu_sel),
      .result_nxt (result_nxt),
      .carry_nxt  (carry_nxt)
   );

   // zero is registered alongside result so both always describe the same op.
   always_ff @(posedge clk) begin
      if (rst) begin
         result    <= '0;
         carry_out <= 1'b0;
         zero      <= 1'b1;
      end else begin
         result    <= result_nxt;
         carry_out <= carry_nxt;
         zero      <= (result_nxt == '0);
      end
   end

endmodule

// File: tb/tb_alu.sv
module tb_alu;
   import alu_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   alu_sel;
   logic [W-1:0] result;
   logic         carry_out;
   logic         zero;

   int checks   = 0;
   int failures = 0;

   alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .alu_sel   (alu_sel),
      .result    (result),
      .carry_out (carry_out),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference model from the operation definitions, plain integer arithmetic.
   task automatic model(input int ua, input int ub, input int op, output int r, output int c);
      int p;
      r = 0;
      c = 0;
      case (op)
         0:  begin p = ua + ub; r = p % 256; c = (p >= 256); end
         1:  begin r = (ua - ub + 256) % 256; c = (ua < ub); end
         2:  begin p = ua * ub; r = p % 256; c = (p >= 256); end
         3:  begin if (ub == 0) begin r = 255; c = 1; end else r = ua / ub; end
         4:  begin r = (ua * 2) % 256; c = (ua >= 128); end
         5:  begin r = ua / 2; c = ua % 2; end
         6:  begin r = (ua * 2) % 256 + ua / 128; c = (ua >= 128); end
         7:  begin r = ua / 2 + (ua % 2) * 128; c = ua % 2; end
         8:  r = ua & ub;
         9:  r = ua | ub;
         10: r = ua ^ ub;
         11: r = (~(ua | ub)) & 255;
         12: r = (~(ua & ub)) & 255;
         13: r = (~(ua ^ ub)) & 255;
         14: r = (ua > ub) ? 1 : 0;
         15: r = (ua == ub) ? 1 : 0;
         default: r = 0;
      endcase
   endtask

   task automatic apply(input int ua, input int ub, input logic [3:0] op);
      a       = ua[W-1:0];
      b       = ub[W-1:0];
      alu_sel = op;
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input string tag, input int ua, input int ub, input logic [3:0] op,
                           input int er, input int ec, input int ez);
      apply(ua, ub, op);
      check({tag, ".res"}, {24'd0, result}, er);
      check({tag, ".c"},   {31'd0, carry_out}, ec);
      check({tag, ".z"},   {31'd0, zero}, ez);
   endtask

   initial begin
      int r, c;
      int ua, ub, op;

      rst = 1'b1;
      a = 8'd77;
      b = 8'd11;
      alu_sel = OP_ADD;
      @(posedge clk);
      #1;
      check("reset.res", {24'd0, result}, 0);
      check("reset.c",   {31'd0, carry_out}, 0);
      check("reset.z",   {31'd0, zero}, 1);
      rst = 1'b0;

      directed("15_3.add",  15, 3, OP_ADD, 18, 0, 0);
      directed("15_3.sub",  15, 3, OP_SUB, 12, 0, 0);
      directed("15_3.mul",  15, 3, OP_MUL, 45, 0, 0);
      directed("15_3.div",  15, 3, OP_DIV,  5, 0, 0);
      directed("15_3.shl",  15, 3, OP_SHL, 30, 0, 0);
      directed("15_3.and",  15, 3, OP_AND,  3, 0, 0);
      directed("15_3.or",   15, 3, OP_OR,  15, 0, 0);
      directed("15_3.xor",  15, 3, OP_XOR, 12, 0, 0);
      directed("15_3.gt",   15, 3, OP_GT,   1, 0, 0);
      directed("15_3.eq",   15, 3, OP_EQ,   0, 0, 1);

      directed("255_1.add",  255, 1, OP_ADD,    0, 1, 1);
      directed("255_1.sub",  255, 1, OP_SUB,  254, 0, 0);
      directed("255_1.mul",  255, 1, OP_MUL,  255, 0, 0);
      directed("255_1.shl",  255, 1, OP_SHL,  254, 1, 0);
      directed("255_1.shr",  255, 1, OP_SHR,  127, 1, 0);
      directed("255_1.rol",  255, 1, OP_ROL,  255, 1, 0);
      directed("255_1.nand", 255, 1, OP_NAND, 254, 0, 0);
      directed("255_1.xnor", 255, 1, OP_XNOR,   1, 0, 0);

      directed("0_0.div", 0, 0, OP_DIV, 255, 1, 0);
      directed("0_0.sub", 0, 0, OP_SUB,   0, 0, 1);
      directed("0_0.eq",  0, 0, OP_EQ,    1, 0, 0);
      directed("0_0.nor", 0, 0, OP_NOR, 255, 0, 0);
      directed("0_0.gt",  0, 0, OP_GT,    0, 0, 1);

      directed("3_5.sub",   3,  5, OP_SUB, 254, 1, 0);
      directed("16_16.mul", 16, 16, OP_MUL,  0, 1, 1);

      // Reset in the middle of a stream wins on its edge.
      rst = 1'b1;
      directed("midrst", 200, 100, OP_ADD, 0, 0, 1);
      rst = 1'b0;
      directed("postrst", 200, 100, OP_ADD, 44, 1, 0);

      // Outputs must hold while the select changes between edges.
      directed("lat.pre", 15, 3, OP_ADD, 18, 0, 0);
      alu_sel = OP_SUB;
      #3;
      check("lat.hold.res", {24'd0, result}, 18);
      alu_sel = OP_MUL;
      #3;
      check("lat.hold2.res", {24'd0, result}, 18);
      @(posedge clk);
      #1;
      check("lat.next.res", {24'd0, result}, 45);

      for (int i = 0; i < 400; i++) begin
         ua = $urandom_range(0, 255);
         ub = (i % 16 == 3) ? 0 : $urandom_range(0, 255);
         op = $urandom_range(0, 15);
         model(ua, ub, op, r, c);
         apply(ua, ub, op[3:0]);
         check($sformatf("rnd%0d.op%0d.res", i, op), {24'd0, result}, r);
         check($sformatf("rnd%0d.op%0d.c", i, op),   {31'd0, carry_out}, c);
         check($sformatf("rnd%0d.op%0d.z", i, op),   {31'd0, zero}, (r == 0) ? 1 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
- REQ-001 Parameter WIDTH, default 8: operand and result width in bits; all widths below scale with it, and verification covers WIDTH=8.
- REQ-002 clk  input  1  single clock; all state updates on its rising edge.
- REQ-003 rst  input  1  reset; synchronous and active-high.
- REQ-004 a  input  WIDTH  operand A, unsigned.
- REQ-005 b  input  WIDTH  operand B, unsigned.
- REQ-006 alu_sel  input  4  operation select; encodings are in REQ-011.
- REQ-007 result  output  WIDTH  registered operation result.
- REQ-008 carry_out  output  1  registered carry, borrow or error flag.
- REQ-009 zero  output  1  registered flag; 1 when result is all zeros.

Function
- REQ-010 On each rising clk edge with rst=0, the block SHALL sample a, b and alu_sel, compute the operation combinationally and register result, carry_out and zero. Latency is 1 cycle; there is no handshake; a new operation is accepted every cycle.
- REQ-011 The encodings SHALL be as follows (carry_out is 0 unless stated):
  - 0 ADD: a+b mod 2^WIDTH; carry = bit WIDTH of the full sum.
  - 1 SUB: a-b mod 2^WIDTH; carry = borrow (1 when a<b).
  - 2 MUL: low WIDTH bits of a*b; carry = 1 when the high WIDTH bits are nonzero.
  - 3 DIV: floor(a/b); carry = 0.
  - 4 SHL: a<<1, zero-filled; carry = a[MSB].
  - 5 SHR: a>>1, logical; carry = a[0].
  - 6 ROL: rotate a left by 1; carry = a[MSB].
  - 7 ROR: rotate a right by 1; carry = a[0].
  - 8 AND: a&b.
  - 9 OR: a|b.
  - 10 XOR: a^b.
  - 11 NOR: ~(a|b).
  - 12 NAND: ~(a&b).
  - 13 XNOR: ~(a^b).
  - 14 GT: result = 1 when a>b (unsigned), else 0.
  - 15 EQ: result = 1 when a==b, else 0.
- REQ-012 DIV with b=0 SHALL give result = all ones and carry_out = 1 (divide error); no X propagation.
- REQ-013 zero SHALL equal (result == 0) for every registered result, including reset.
- REQ-014 All arithmetic SHALL be unsigned; results wrap modulo 2^WIDTH with no saturation.
- REQ-015 Shift and rotate operations SHALL ignore b.
- REQ-016 Outputs SHALL hold their values between edges and SHALL never be X after the first reset.

Reset
- REQ-017 While rst=1 at a rising edge: result SHALL be 0, carry_out 0 and zero 1, regardless of other inputs.
- REQ-018 If rst is asserted while operations are being issued, the reset value SHALL win on that edge; the first edge with rst=0 registers the operation presented at that edge.
- REQ-019 There SHALL be no asynchronous reset path.

Structure
- REQ-020 A shared package (alu_pkg) SHALL hold the 4-bit opcode constants OP_ADD..OP_EQ and the default width constant.
- REQ-021 One combinational sub-module, alu_comb, SHALL compute the next result and carry from a, b and sel.
- REQ-022 alu SHALL instantiate alu_comb and add only the output registers and the zero flag logic.
- REQ-023 The opcode decode SHALL be a complete case with a default branch that gives result 0 and carry 0.

Verification
- REQ-024 a=15, b=3, one cycle per operation:
  - ADD -> 18, c=0.
  - SUB -> 12, c=0.
  - MUL -> 45, c=0.
  - DIV -> 5.
  - SHL -> 30.
  - AND -> 3.
  - OR -> 15.
  - XOR -> 12.
  - GT -> 1.
  - EQ -> 0.
- REQ-025 a=255, b=1:
  - ADD -> 0, c=1, z=1.
  - SUB -> 254, c=0.
  - MUL -> 255, c=0.
  - SHL -> 254, c=1.
  - SHR -> 127, c=1.
  - ROL -> 255, c=1.
  - NAND -> 254.
  - XNOR -> 1.
- REQ-026 a=0, b=0:
  - DIV -> 255, c=1, z=0.
  - SUB -> 0, z=1.
  - EQ -> 1.
  - NOR -> 255.
  - GT -> 0, z=1.
- REQ-027 a=3, b=5: SUB -> 254, c=1. a=16, b=16: MUL -> 0, c=1, z=1.
- REQ-028 rst=1 mid-sequence with ADD 200+100 presented -> next edge gives result=0, c=0, z=1; releasing rst -> next edge gives 44, c=1.
- REQ-029 Latency check: change alu_sel between edges -> outputs must not change until the next rising edge.
